cscv2_serial_tx: RTL

- Downstream consumer of the CPU's output path: accepts the 8-bit A:B output byte whenever the CPU asserts its TX control line.
- Buffers bytes in a small FIFO and shifts each one out as 8N1 asynchronous serial on a physical pin.
- Replaces the simulation-only UART model in hardware builds; sits between the cscv2 core and the board's serial pin.

---
 rtl/cscv2_serial_pkg.sv | 31 +++
 rtl/cscv2_byte_fifo.sv | 71 +++++++
 rtl/cscv2_serial_tx.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/cscv2_serial_pkg.sv
// ============================================================================
// cscv2_serial_pkg : shared types and constants for the cscv2 serial transmitter
// Revision 1.0
// ============================================================================
`default_nettype none

package cscv2_serial_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  localparam int BITS_PER_FRAME = 10;
  localparam int DATA_BITS      = BITS_PER_FRAME - 2;

  // Bits needed to hold values 0..n-1, never less than 1.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cscv2_byte_fifo.sv
// ============================================================================
// cscv2_byte_fifo : show-ahead byte FIFO with registered occupancy
// Revision 1.0
// ============================================================================
`default_nettype none

module cscv2_byte_fifo
  import cscv2_serial_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       dblclk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       empty,
  output logic       full
);

  localparam int           AW       = clog2(DEPTH);
  localparam logic [AW:0]  FULL_CNT = (AW + 1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q,  count_d;
  logic          do_wr;
  logic          do_rd;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_CNT);
  assign rd_data = mem_q[rd_ptr_q];

  // A read frees a slot in the same cycle, so a write alongside it is legal when full.
  assign do_rd = rd_en & ~empty;
  assign do_wr = wr_en & (~full | do_rd);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge dblclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge dblclk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

`default_nettype wire

// File: rtl/cscv2_serial_tx.sv
// ============================================================================
// cscv2_serial_tx : captures CPU output bytes and sends them as 8N1 serial
// Revision 1.0
// ============================================================================
`default_nettype none

module cscv2_serial_tx
  import cscv2_serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       dblclk,
  input  logic       rst_n,
  input  logic [7:0] data_in,
  input  logic       tx_req,
  output logic       ser_out,
  output logic       busy,
  output logic       fifo_full,
  output logic       overrun
);

  localparam int            BW        = clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);

  tx_state_e     state_q,   state_d;
  logic [BW-1:0] baud_q,    baud_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q,   shift_d;
  logic          ser_q,     ser_d;
  logic          overrun_q, overrun_d;
  logic          tx_req_q;

  logic          capture;
  logic          baud_last;
  logic          pop;
  logic          push;
  logic          fifo_empty;
  logic          fifo_full_w;
  logic [7:0]    fifo_rd_data;

  assign capture   = tx_req & ~tx_req_q;
  assign baud_last = (baud_q == BAUD_LAST);
  assign push      = capture & (~fifo_full_w | pop);
  assign overrun_d = overrun_q | (capture & fifo_full_w & ~pop);

  cscv2_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .dblclk  (dblclk),
    .rst_n   (rst_n),
    .wr_en   (push),
    .wr_data (data_in),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .empty   (fifo_empty),
    .full    (fifo_full_w)
  );

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_rd_data;
          baud_d  = '0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (baud_last) begin
          baud_d    = '0;
          bit_idx_d = '0;
          state_d   = ST_DATA;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      ST_DATA: begin
        if (baud_last) begin
          baud_d    = '0;
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == LAST_BIT) state_d = ST_STOP;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      ST_STOP: begin
        if (baud_last) begin
          baud_d = '0;
          // Chain straight into the next frame when more data is waiting.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_rd_data;
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Line level follows the current state one cycle later from a flop.
  always_comb begin
    ser_d = 1'b1;
    case (state_q)
      ST_START: ser_d = 1'b0;
      ST_DATA:  ser_d = shift_q[0];
      default:  ser_d = 1'b1;
    endcase
  end

  always_ff @(posedge dblclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      ser_q     <= 1'b1;
      overrun_q <= 1'b0;
      tx_req_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      ser_q     <= ser_d;
      overrun_q <= overrun_d;
      tx_req_q  <= tx_req;
    end
  end

  assign ser_out   = ser_q;
  assign busy      = (state_q != ST_IDLE) | ~fifo_empty;
  assign fifo_full = fifo_full_w;
  assign overrun   = overrun_q;

endmodule

`default_nettype wire
